seed_core_arbiter: RTL and testbench
====================================

Name: seed_core_arbiter

Overview:
- Shares one SEED core (CLK/EN/Drdy/Krdy/EncDec/Din/Kin in; Dout/Dvld/Kvld/BSY out) between two requesters.
- Round-robin arbitration between the two requesters.
- Caches the currently loaded key and mode, and skips key setup on a hit.
- Sequences the core's Krdy/Drdy strobes, returns each result to the granted channel, and aborts hung operations with a watchdog.

Parameters:
TIMEOUT, 64, max cycles waited for core_Kvld or core_Dvld before abort (legal range 2..255)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
req0 / req1  in  1  channel request; operands held stable while high
encdec0 / encdec1  in  1  0 = encrypt, 1 = decrypt
key0 / key1  in  128  channel key
din0 / din1  in  128  channel data block
ack0 / ack1  out  1  one-cycle pulse: operands latched
done0 / done1  out  1  one-cycle pulse: operation finished (result or error)
err0 / err1  out  1  one-cycle pulse with done_N: watchdog abort
dout  out  128  last result; valid from the done cycle until the next capture
key_flush  in  1  invalidates the key cache
core_EN  out  1  tied 1
core_Kin / core_Din  out  128  latched operand registers
core_EncDec  out  1  latched mode
core_Krdy / core_Drdy  out  1  core strobes
core_Dout  in  128  core result
core_Dvld / core_Kvld / core_BSY  in  1  core status

Behaviour:
- Reset (async, RST=1):
  - state=IDLE; all ack/done/err=0; core_Krdy=core_Drdy=0.
  - dout=0, core_Kin=core_Din=0, core_EncDec=0.
  - key_valid=0; rr_last=1, so ch0 wins the first tie.
  - Reset mid-operation abandons the operation silently; no done is issued.
- States: IDLE, KEY, KWAIT, DATA, DWAIT, RESP.
- IDLE:
  - If any req is high, grant one. If both are high, grant the channel != rr_last.
  - Next edge: latch key/din/encdec into core_* registers, set gnt and rr_last=gnt, pulse ack_gnt for 1 cycle.
  - Go to DATA on a cache hit, else to KEY.
  - Cache hit = key_valid && key==cached_key && encdec==cached_encdec.
- KEY:
  - core_Krdy=1 for exactly 1 cycle; clear key_valid.
  - Go to KWAIT; wdog=0.
- KWAIT:
  - On core_Kvld: key_valid=1, cached_key=core_Kin, cached_encdec=core_EncDec; go to DATA.
  - Else wdog++.
- DATA:
  - core_Drdy = !core_BSY (combinational from state and BSY).
  - When !core_BSY, go to DWAIT; wdog=0. Otherwise hold in DATA; no timeout applies in this state.
- DWAIT:
  - On core_Dvld: dout<=core_Dout; go to RESP.
  - Else wdog++.
- RESP: done_gnt=1 for 1 cycle; go to IDLE.
- Timeout:
  - In KWAIT or DWAIT with wdog==TIMEOUT-1 and no valid: go to RESP with err_gnt=1 alongside done.
  - key_valid=0; dout is unchanged.
- ack_N, done_N and err_N are registered outputs.
- core_Krdy is decoded from the state register.
- Requester protocol:
  - Must deassert req on the cycle after ack, else the request is treated as a new one at the next IDLE.
  - Operands may change after ack.
  - A losing requester simply keeps req high.
- key_flush:
  - Clears key_valid on the next edge in any state.
  - If it coincides with core_Kvld, flush wins (key_valid=0).
  - The current operation completes normally.
- A core_Dvld or core_Kvld arriving outside its wait state is ignored.
- Latency from req sampled in IDLE (BSY low) to done:
  - Cache hit: 1 (ack) + 1 (DATA) + core latency + 1 (RESP).
  - Miss: additionally 1 cycle for KEY plus the key-schedule time.
- Back-to-back: IDLE follows RESP, so at most one idle cycle occurs between operations.

Test Plan:
- Reset, then req0 with key=0, encdec=0, din=0001_0203_0405_0607_0809_0a0b_0c0d_0e0f → ack0, one core_Krdy pulse, then done0 with dout=5eba_c6e0_054e_1668_19af_f1cc_6d34_6cdb, err0=0.
- Repeat the same request on ch0 → no core_Krdy (cache hit), same dout; then key_flush and repeat → core_Krdy reappears.
- req0 and req1 high together: ch1 has key=0001_0203_0405_0607_0809_0a0b_0c0d_0e0f, din=0, encdec=0 → ch0 is served first, then ch1 with dout=c11f_22f2_0140_5050_8448_3597_e437_0f43; the next tie goes to ch0 again (alternation).
- Decrypt with ch1: key=4706_4808_51e6_1be8_5d74_bfb3_fd95_6185, din=ee54_d13e_bcae_706d_226b_c314_2cd4_0d4a, encdec=1 → core_Krdy issued (mode change), dout=83a2_f8a2_8864_1fb9_a4e9_a5cc_2f13_1c7d.
- Core model that never raises Dvld, TIMEOUT=64 → done0 and err0 pulse 64 cycles after entering DWAIT; dout unchanged; the next request reloads the key.
- RST asserted during DWAIT → all outputs 0 immediately; no done; the next request performs a key load.

Source files
------------

// File: rtl/seed_core_arbiter.sv
// Two-channel round-robin front end for a shared SEED core.
// Caches the loaded key and mode, sequences Krdy/Drdy, and aborts hung core operations.
module seed_core_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req0,
  input  logic         req1,
  input  logic         encdec0,
  input  logic         encdec1,
  input  logic [127:0] key0,
  input  logic [127:0] key1,
  input  logic [127:0] din0,
  input  logic [127:0] din1,
  output logic         ack0,
  output logic         ack1,
  output logic         done0,
  output logic         done1,
  output logic         err0,
  output logic         err1,
  output logic [127:0] dout,
  input  logic         key_flush,
  output logic         core_EN,
  output logic [127:0] core_Kin,
  output logic [127:0] core_Din,
  output logic         core_EncDec,
  output logic         core_Krdy,
  output logic         core_Drdy,
  input  logic [127:0] core_Dout,
  input  logic         core_Dvld,
  input  logic         core_Kvld,
  input  logic         core_BSY
);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_KWAIT, S_DATA, S_DWAIT, S_RESP} state_e;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e       state_q;
  logic         gnt_q, rr_last_q;
  logic         key_valid_q, cached_encdec_q;
  logic [127:0] cached_key_q;
  logic [7:0]   wdog_q;
  logic [127:0] dout_q, kin_q, din_q;
  logic         encdec_q;
  logic         ack0_q, ack1_q, done0_q, done1_q, err0_q, err1_q;

  logic         gnt_d, encdec_d, hit_d;
  logic [127:0] key_d, din_d;

  always_comb begin
    gnt_d = req1;
    if (req0 && req1) gnt_d = ~rr_last_q;
    key_d    = gnt_d ? key1 : key0;
    din_d    = gnt_d ? din1 : din0;
    encdec_d = gnt_d ? encdec1 : encdec0;
    hit_d    = key_valid_q && (key_d == cached_key_q) && (encdec_d == cached_encdec_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= S_IDLE;
      gnt_q           <= 1'b0;
      rr_last_q       <= 1'b1;
      key_valid_q     <= 1'b0;
      cached_key_q    <= '0;
      cached_encdec_q <= 1'b0;
      wdog_q          <= '0;
      dout_q          <= '0;
      kin_q           <= '0;
      din_q           <= '0;
      encdec_q        <= 1'b0;
      ack0_q          <= 1'b0;
      ack1_q          <= 1'b0;
      done0_q         <= 1'b0;
      done1_q         <= 1'b0;
      err0_q          <= 1'b0;
      err1_q          <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            kin_q     <= key_d;
            din_q     <= din_d;
            encdec_q  <= encdec_d;
            gnt_q     <= gnt_d;
            rr_last_q <= gnt_d;
            ack0_q    <= ~gnt_d;
            ack1_q    <= gnt_d;
            state_q   <= hit_d ? S_DATA : S_KEY;
          end
        end
        S_KEY: begin
          key_valid_q <= 1'b0;
          wdog_q      <= '0;
          state_q     <= S_KWAIT;
        end
        S_KWAIT: begin
          if (core_Kvld) begin
            key_valid_q     <= 1'b1;
            cached_key_q    <= kin_q;
            cached_encdec_q <= encdec_q;
            state_q         <= S_DATA;
          end else if (wdog_q == WDOG_LAST) begin
            key_valid_q <= 1'b0;
            done0_q     <= ~gnt_q;
            done1_q     <= gnt_q;
            err0_q      <= ~gnt_q;
            err1_q      <= gnt_q;
            state_q     <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        // The core may still be busy from a previous block; wait without a watchdog.
        S_DATA: begin
          if (!core_BSY) begin
            wdog_q  <= '0;
            state_q <= S_DWAIT;
          end
        end
        S_DWAIT: begin
          if (core_Dvld) begin
            dout_q  <= core_Dout;
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
            state_q <= S_RESP;
          end else if (wdog_q == WDOG_LAST) begin
            key_valid_q <= 1'b0;
            done0_q     <= ~gnt_q;
            done1_q     <= gnt_q;
            err0_q      <= ~gnt_q;
            err1_q      <= gnt_q;
            state_q     <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      // A flush overrides any key-valid update made above, including a coincident Kvld.
      if (key_flush) key_valid_q <= 1'b0;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign dout        = dout_q;
  assign core_EN     = 1'b1;
  assign core_Kin    = kin_q;
  assign core_Din    = din_q;
  assign core_EncDec = encdec_q;
  assign core_Krdy   = (state_q == S_KEY);
  assign core_Drdy   = (state_q == S_DATA) && !core_BSY;

endmodule

// File: tb/tb_seed_core_arbiter.sv
// Scoreboard bench for seed_core_arbiter: a behavioural SEED-core stand-in plus an
// operation-level model of arbitration, key caching and watchdog abort.
module tb_seed_core_arbiter;

  localparam int TIMEOUT = 64;

  localparam logic [127:0] PT1 = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
  localparam logic [127:0] CT1 = 128'h5eba_c6e0_054e_1668_19af_f1cc_6d34_6cdb;
  localparam logic [127:0] K2  = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
  localparam logic [127:0] CT2 = 128'hc11f_22f2_0140_5050_8448_3597_e437_0f43;
  localparam logic [127:0] K3  = 128'h4706_4808_51e6_1be8_5d74_bfb3_fd95_6185;
  localparam logic [127:0] PT3 = 128'h83a2_f8a2_8864_1fb9_a4e9_a5cc_2f13_1c7d;
  localparam logic [127:0] CT3 = 128'hee54_d13e_bcae_706d_226b_c314_2cd4_0d4a;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic         encdec0 = 1'b0, encdec1 = 1'b0;
  logic [127:0] key0 = '0, key1 = '0, din0 = '0, din1 = '0;
  logic         ack0, ack1, done0, done1, err0, err1;
  logic [127:0] dout;
  logic         key_flush = 1'b0;
  logic         core_EN;
  logic [127:0] core_Kin, core_Din;
  logic         core_EncDec, core_Krdy, core_Drdy;
  logic [127:0] core_Dout;
  logic         core_Dvld, core_Kvld, core_BSY;

  seed_core_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .encdec0(encdec0), .encdec1(encdec1),
    .key0(key0), .key1(key1), .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .dout(dout), .key_flush(key_flush),
    .core_EN(core_EN), .core_Kin(core_Kin), .core_Din(core_Din),
    .core_EncDec(core_EncDec), .core_Krdy(core_Krdy), .core_Drdy(core_Drdy),
    .core_Dout(core_Dout), .core_Dvld(core_Dvld), .core_Kvld(core_Kvld),
    .core_BSY(core_BSY)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d,
                                          input logic m);
    if (!m && k == '0 && d == PT1) return CT1;
    if (!m && k == K2 && d == '0)  return CT2;
    if (!m && k == K3 && d == PT3) return CT3;
    if (m && k == K3 && d == CT3)  return PT3;
    return {d[126:0], d[127]} ^ k ^ {128{m}};
  endfunction

  // ---------------- core stand-in ----------------
  bit           hang = 1'b0;
  int           klat = 3, dlat = 4, tail = 0;
  int           kcnt, dcnt, tcnt;
  logic [127:0] core_key_m, pend_din;
  logic         pend_mode;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      core_Kvld <= 1'b0;
      core_Dvld <= 1'b0;
      core_BSY  <= 1'b0;
      core_Dout <= '0;
      kcnt <= 0; dcnt <= 0; tcnt <= 0;
    end else begin
      core_Kvld <= 1'b0;
      core_Dvld <= 1'b0;
      if (core_Krdy) begin
        core_key_m <= core_Kin;
        kcnt <= klat;
      end else if (kcnt > 0) begin
        if (kcnt == 1) core_Kvld <= 1'b1;
        kcnt <= kcnt - 1;
      end
      if (core_Drdy) begin
        pend_din  <= core_Din;
        pend_mode <= core_EncDec;
        if (!hang) begin
          core_BSY <= 1'b1;
          dcnt <= dlat;
        end
      end else if (dcnt > 0) begin
        if (dcnt == 1) begin
          core_Dvld <= 1'b1;
          core_Dout <= cipher(core_key_m, pend_din, pend_mode);
          if (tail == 0) core_BSY <= 1'b0;
          else tcnt <= tail;
        end
        dcnt <= dcnt - 1;
      end else if (tcnt > 0) begin
        if (tcnt == 1) core_BSY <= 1'b0;
        tcnt <= tcnt - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int           ch;
    bit           load;
    bit           err;
    logic [127:0] dout;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] op_key[2], op_din[2];
  logic         op_mode[2];
  bit           m_kv = 0;
  logic [127:0] m_key = '0, m_dout = '0;
  logic         m_mode = 1'b0;
  int           m_rr = 1;

  task automatic model_op(input int ch);
    exp_t e;
    e.ch   = ch;
    e.load = !(m_kv && op_key[ch] == m_key && op_mode[ch] == m_mode);
    e.err  = hang;
    if (hang) m_kv = 0;
    else begin
      m_dout = cipher(op_key[ch], op_din[ch], op_mode[ch]);
      m_kv   = 1;
      m_key  = op_key[ch];
      m_mode = op_mode[ch];
    end
    e.dout = m_dout;
    m_rr   = ch;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0, drdy_cyc = 0, krdy_cnt = 0;

  always @(negedge CLK) begin
    if (RST) krdy_cnt = 0;
    else begin
      exp_t e;
      cyc++;
      if (core_Krdy) krdy_cnt++;
      if (core_Drdy) drdy_cyc = cyc;
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) chk("ack_unexpected", {ack1, ack0}, 2'b00);
        else chk("ack_ch", {ack1, ack0}, (exp_q[0].ch == 1) ? 2'b10 : 2'b01);
      end
      if (done0 || done1) begin
        if (exp_q.size() == 0) chk("done_unexpected", {done1, done0}, 2'b00);
        else begin
          e = exp_q.pop_front();
          chk("done_ch", {done1, done0}, (e.ch == 1) ? 2'b10 : 2'b01);
          chk("err", {err1, err0}, e.err ? ((e.ch == 1) ? 2'b10 : 2'b01) : 2'b00);
          chk("dout", dout, e.dout);
          chk("krdy_pulses", krdy_cnt, e.load ? 1 : 0);
          if (e.err) chk("timeout_latency", cyc - drdy_cyc, TIMEOUT + 1);
          krdy_cnt = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_ops();
    key0 = op_key[0]; din0 = op_din[0]; encdec0 = op_mode[0];
    key1 = op_key[1]; din1 = op_din[1]; encdec1 = op_mode[1];
  endtask

  task automatic run_tx(input bit r0, input bit r1);
    int need, got, cnt, first;
    need = int'(r0) + int'(r1);
    if (r0 && r1) begin
      first = (m_rr == 1) ? 0 : 1;
      model_op(first);
      model_op(1 - first);
    end else model_op(r1 ? 1 : 0);
    drive_ops();
    req0 = r0; req1 = r1;
    got = 0; cnt = 0;
    while (got < need && cnt < 3000) begin
      @(posedge CLK); #1;
      cnt++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      if (done0) got++;
      if (done1) got++;
    end
    if (got < need) begin
      tests++; fails++;
      $display("FAIL tx_timeout: got %0d dones expected %0d", got, need);
      req0 = 1'b0; req1 = 1'b0;
    end
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    req0 = 1'b0; req1 = 1'b0; key_flush = 1'b0;
    RST = 1'b1;
    #2;
    chk("rst_ack",  {ack1, ack0}, 2'b00);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_err",  {err1, err0}, 2'b00);
    chk("rst_dout", dout, '0);
    chk("rst_strobes", {core_Krdy, core_Drdy}, 2'b00);
    chk("rst_kin", core_Kin, '0);
    chk("rst_din", core_Din, '0);
    chk("rst_encdec", core_EncDec, 1'b0);
    chk("core_en", core_EN, 1'b1);
    exp_q.delete();
    m_kv = 0; m_rr = 1; m_dout = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic flush();
    key_flush = 1'b1;
    @(posedge CLK); #1;
    key_flush = 1'b0;
    m_kv = 0;
  endtask

  task automatic set_op(input int ch, input logic [127:0] k, input logic [127:0] d,
                        input logic m);
    op_key[ch] = k; op_din[ch] = d; op_mode[ch] = m;
  endtask

  logic [127:0] pool[3];

  initial begin
    int cnt;
    set_op(0, '0, '0, 1'b0);
    set_op(1, '0, '0, 1'b0);
    apply_reset();

    set_op(0, '0, PT1, 1'b0);
    run_tx(1, 0);
    run_tx(1, 0);
    flush();
    run_tx(1, 0);

    apply_reset();
    set_op(1, K2, '0, 1'b0);
    run_tx(1, 1);
    run_tx(1, 1);

    set_op(1, K3, CT3, 1'b1);
    run_tx(0, 1);

    for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      int pat;
      for (int c = 0; c < 2; c++)
        set_op(c, pool[$urandom_range(0, 2)], {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)));
      klat = $urandom_range(1, 6);
      dlat = $urandom_range(1, 10);
      tail = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) flush();
      pat = $urandom_range(1, 3);
      run_tx(pat[0], pat[1]);
    end
    tail = 0;

    set_op(0, pool[0], PT1, 1'b0);
    hang = 1'b1;
    run_tx(1, 0);
    hang = 1'b0;
    run_tx(1, 0);

    // Reset while the core is stalled in the data wait.
    hang = 1'b1;
    set_op(0, pool[1], PT3, 1'b0);
    model_op(0);
    drive_ops();
    req0 = 1'b1;
    cnt = 0;
    while (!core_Drdy && cnt < 500) begin
      @(posedge CLK); #1;
      cnt++;
      if (ack0) req0 = 1'b0;
    end
    chk("reach_data", core_Drdy, 1'b1);
    repeat (5) @(posedge CLK);
    #1;
    apply_reset();
    hang = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    run_tx(1, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
